// File: rtl/dnn_output_evaluator.sv
// ---------------------------------------------------------------------------
// dnn_output_evaluator
//
// Purpose:
//   Sits at the output end of the DNN stream. Over each block cycle it
//   collects the per-clock output neurons (a_out = thresholded prediction,
//   y_out = ideal target) into full NOUT-bit vectors and judges each training
//   case as correct or wrong. It keeps running statistics: the total number
//   of cases, the total number of wrong cases, and (optionally) the number of
//   correct cases among the most recent WINDOW cases.
//
// Optional feature macro:
//   EVAL_MOVING_WINDOW_EN - when defined, the moving-window buffer, pointer
//   and recent_correct counter are built. When undefined, recent_correct is
//   tied to 0 and everything else behaves the same.
//
// Ports:
//   clk            in   system clock, all state on the rising edge
//   reset          in   asynchronous active-high reset
//   cycle_index    in   block-cycle position from the shared block counter
//   a_out          in   ZPC thresholded actual outputs for this clock
//   y_out          in   ZPC ideal outputs for this clock
//   case_valid     out  one-clock pulse when a case is judged
//   case_correct   out  result of the last judged case (held)
//   pred_vec       out  predicted vector of the last judged case
//   ideal_vec      out  ideal vector of the last judged case
//   total_cases    out  cases judged since reset (saturating)
//   total_errors   out  cases with at least one mismatch (saturating)
//   recent_correct out  correct cases among the last min(total, WINDOW)
// ---------------------------------------------------------------------------
module dnn_output_evaluator #(
  parameter int NOUT       = 16,
  parameter int ZPC        = 1,
  parameter int CPC        = 18,
  parameter int PIPE_DELAY = 2,
  parameter int WINDOW     = 100,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(CPC)-1:0]       cycle_index,
  input  logic [ZPC-1:0]               a_out,
  input  logic [ZPC-1:0]               y_out,
  output logic                         case_valid,
  output logic                         case_correct,
  output logic [NOUT-1:0]              pred_vec,
  output logic [NOUT-1:0]              ideal_vec,
  output logic [CNT_W-1:0]             total_cases,
  output logic [CNT_W-1:0]             total_errors,
  output logic [$clog2(WINDOW+1)-1:0]  recent_correct
);

  localparam int CI_W  = $clog2(CPC);
  localparam int RC_W  = $clog2(WINDOW + 1);
  localparam int NSLOT = NOUT / ZPC;

  // Working capture state for the case currently streaming in.
  logic [NOUT-1:0]  pred_work_r;
  logic [NOUT-1:0]  ideal_work_r;
  logic             mismatch_r;
  logic             armed_r;

  // Registered outputs.
  logic             case_valid_r;
  logic             case_correct_r;
  logic [NOUT-1:0]  pred_vec_r;
  logic [NOUT-1:0]  ideal_vec_r;
  logic [CNT_W-1:0] total_cases_r;
  logic [CNT_W-1:0] total_errors_r;

  // Decode of the current block-cycle position.
  logic             cap_s;
  logic             first_s;
  logic             last_s;
  logic             finalise_s;
  logic [CI_W-1:0]  slot_s;
  logic             mis_s;
  logic             mismatch_nxt_s;
  logic             armed_nxt_s;
  logic [NOUT-1:0]  pred_nxt_s;
  logic [NOUT-1:0]  ideal_nxt_s;
  logic [CNT_W-1:0] total_cases_nxt_s;
  logic [CNT_W-1:0] total_errors_nxt_s;

  assign cap_s   = (cycle_index >= CI_W'(PIPE_DELAY)) && (cycle_index <= CI_W'(CPC - 1));
  assign first_s = (cycle_index == CI_W'(PIPE_DELAY));
  assign last_s  = (cycle_index == CI_W'(CPC - 1));
  assign slot_s  = cycle_index - CI_W'(PIPE_DELAY);
  assign mis_s   = (a_out != y_out);

  // The case is judged on the edge that samples the last slot, so the
  // registered result is visible while cycle_index==0 of the next block.
  // A case that starts at the first slot is armed in the same edge, which
  // also covers the single-slot configuration.
  assign finalise_s = last_s && (armed_r || first_s);

  // Next-state of the sticky mismatch flag; the first slot starts fresh.
  always_comb begin
    mismatch_nxt_s = mismatch_r;
    if (first_s) begin
      mismatch_nxt_s = mis_s;
    end else if (cap_s) begin
      mismatch_nxt_s = mismatch_r | mis_s;
    end else begin
      mismatch_nxt_s = mismatch_r;
    end
  end

  // Next-state of the armed flag: set at the first slot, cleared on judge.
  // A restart at the first slot while armed simply re-arms, discarding the
  // partial case because the working state is overwritten.
  always_comb begin
    armed_nxt_s = armed_r;
    if (finalise_s) begin
      armed_nxt_s = 1'b0;
    end else if (first_s) begin
      armed_nxt_s = 1'b1;
    end else begin
      armed_nxt_s = armed_r;
    end
  end

  // Working vectors with the current slot's slice replaced by this clock's data.
  always_comb begin
    pred_nxt_s  = pred_work_r;
    ideal_nxt_s = ideal_work_r;
    for (int s = 0; s < NSLOT; s++) begin
      if (cap_s && (slot_s == CI_W'(s))) begin
        pred_nxt_s[s*ZPC +: ZPC]  = a_out;
        ideal_nxt_s[s*ZPC +: ZPC] = y_out;
      end else begin
        pred_nxt_s[s*ZPC +: ZPC]  = pred_work_r[s*ZPC +: ZPC];
        ideal_nxt_s[s*ZPC +: ZPC] = ideal_work_r[s*ZPC +: ZPC];
      end
    end
  end

  // Saturating increments of the running totals.
  always_comb begin
    total_cases_nxt_s  = total_cases_r;
    total_errors_nxt_s = total_errors_r;
    if (total_cases_r != {CNT_W{1'b1}}) begin
      total_cases_nxt_s = total_cases_r + CNT_W'(1);
    end else begin
      total_cases_nxt_s = total_cases_r;
    end
    if (mismatch_nxt_s && (total_errors_r != {CNT_W{1'b1}})) begin
      total_errors_nxt_s = total_errors_r + CNT_W'(1);
    end else begin
      total_errors_nxt_s = total_errors_r;
    end
  end

  // Capture registers: working vectors, sticky mismatch and armed flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_work_r  <= {NOUT{1'b0}};
      ideal_work_r <= {NOUT{1'b0}};
      mismatch_r   <= 1'b0;
      armed_r      <= 1'b0;
    end else begin
      pred_work_r  <= pred_nxt_s;
      ideal_work_r <= ideal_nxt_s;
      mismatch_r   <= mismatch_nxt_s;
      armed_r      <= armed_nxt_s;
    end
  end

  // Judged-case result registers and running totals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      case_valid_r   <= 1'b0;
      case_correct_r <= 1'b0;
      pred_vec_r     <= {NOUT{1'b0}};
      ideal_vec_r    <= {NOUT{1'b0}};
      total_cases_r  <= {CNT_W{1'b0}};
      total_errors_r <= {CNT_W{1'b0}};
    end else begin
      case_valid_r <= finalise_s;
      if (finalise_s) begin
        case_correct_r <= ~mismatch_nxt_s;
        pred_vec_r     <= pred_nxt_s;
        ideal_vec_r    <= ideal_nxt_s;
        total_cases_r  <= total_cases_nxt_s;
        total_errors_r <= total_errors_nxt_s;
      end
    end
  end

`ifdef EVAL_MOVING_WINDOW_EN
  localparam int PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  // One bit per recent case: 1 = correct. Unfilled entries stay 0 so the
  // eviction term contributes nothing until the buffer has wrapped once.
  logic [WINDOW-1:0] win_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [RC_W-1:0]   recent_r;
  logic              new_s;
  logic              old_s;
  logic [RC_W-1:0]   recent_nxt_s;
  logic [PTR_W-1:0]  ptr_nxt_s;

  assign new_s = ~mismatch_nxt_s;
  assign old_s = win_r[ptr_r];

  // Window count update and circular pointer advance.
  always_comb begin
    recent_nxt_s = recent_r + RC_W'(new_s) - RC_W'(old_s);
    if (ptr_r == PTR_W'(WINDOW - 1)) begin
      ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      ptr_nxt_s = ptr_r + PTR_W'(1);
    end
  end

  // Moving-window buffer, pointer and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_r    <= {WINDOW{1'b0}};
      ptr_r    <= {PTR_W{1'b0}};
      recent_r <= {RC_W{1'b0}};
    end else if (finalise_s) begin
      win_r[ptr_r] <= new_s;
      ptr_r        <= ptr_nxt_s;
      recent_r     <= recent_nxt_s;
    end
  end

  assign recent_correct = recent_r;
`else
  assign recent_correct = {RC_W{1'b0}};
`endif

  assign case_valid   = case_valid_r;
  assign case_correct = case_correct_r;
  assign pred_vec     = pred_vec_r;
  assign ideal_vec    = ideal_vec_r;
  assign total_cases  = total_cases_r;
  assign total_errors = total_errors_r;

endmodule

// File: tb/tb_dnn_output_evaluator.sv
// ---------------------------------------------------------------------------
// tb_dnn_output_evaluator
//
// Directed bench for dnn_output_evaluator (NOUT=16, ZPC=1, CPC=18).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that samples the last slot (cycle_index==0 phase).
// Expected totals and the moving-window count come from a small queue model.
// ---------------------------------------------------------------------------
module tb_dnn_output_evaluator;

  logic        clk;
  logic        reset;
  logic [4:0]  cycle_index;
  logic [0:0]  a_out;
  logic [0:0]  y_out;
  logic        case_valid;
  logic        case_correct;
  logic [15:0] pred_vec;
  logic [15:0] ideal_vec;
  logic [31:0] total_cases;
  logic [31:0] total_errors;
  logic [6:0]  recent_correct;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int exp_total = 0;
  int exp_err   = 0;
  bit win_q[$];

  dnn_output_evaluator dut (
    .clk            (clk),
    .reset          (reset),
    .cycle_index    (cycle_index),
    .a_out          (a_out),
    .y_out          (y_out),
    .case_valid     (case_valid),
    .case_correct   (case_correct),
    .pred_vec       (pred_vec),
    .ideal_vec      (ideal_vec),
    .total_cases    (total_cases),
    .total_errors   (total_errors),
    .recent_correct (recent_correct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_recent();
    int sum = 0;
`ifdef EVAL_MOVING_WINDOW_EN
    foreach (win_q[i]) sum += int'(win_q[i]);
`endif
    return sum;
  endfunction

  task automatic model_clear();
    exp_total = 0;
    exp_err   = 0;
    win_q.delete();
  endtask

  // Drive cycle_index lo..hi; slots below 2 carry mismatching garbage if asked.
  task automatic drive(input int lo, input int hi, input logic [15:0] y,
                       input logic [15:0] a, input bit garbage);
    for (int c = lo; c <= hi; c++) begin
      @(negedge clk);
      cycle_index = 5'(c);
      if (c >= 2) begin
        a_out = a[c-2];
        y_out = y[c-2];
      end else begin
        a_out = garbage ? 1'b1 : 1'b0;
        y_out = 1'b0;
      end
    end
  endtask

  // One full block, then check the judged result in the cycle_index==0 phase.
  task automatic judge(input string tag, input logic [15:0] y, input logic [15:0] a,
                       input bit garbage, input bit vec_chk);
    bit ok;
    drive(0, 17, y, a, garbage);
    @(negedge clk);
    cycle_index = 5'd0;
    a_out = 1'b0;
    y_out = 1'b0;
    ok = (a == y);
    exp_total++;
    if (!ok) exp_err++;
    win_q.push_back(ok);
    if (win_q.size() > 100) void'(win_q.pop_front());
    chk({tag, "_valid"},   32'(case_valid), 32'd1);
    chk({tag, "_correct"}, 32'(case_correct), 32'(ok));
    chk({tag, "_total"},   total_cases, 32'(exp_total));
    chk({tag, "_errors"},  total_errors, 32'(exp_err));
    chk({tag, "_recent"},  32'(recent_correct), 32'(model_recent()));
    if (vec_chk) begin
      chk({tag, "_pred"},  32'(pred_vec), 32'(a));
      chk({tag, "_ideal"}, 32'(ideal_vec), 32'(y));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},   32'(case_valid), 32'd0);
    chk({tag, "_correct"}, 32'(case_correct), 32'd0);
    chk({tag, "_pred"},    32'(pred_vec), 32'd0);
    chk({tag, "_ideal"},   32'(ideal_vec), 32'd0);
    chk({tag, "_total"},   total_cases, 32'd0);
    chk({tag, "_errors"},  total_errors, 32'd0);
    chk({tag, "_recent"},  32'(recent_correct), 32'd0);
  endtask

  // Directed stimulus sequence.
  initial begin
    reset       = 1'b1;
    cycle_index = 5'd0;
    a_out       = 1'b0;
    y_out       = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // All slots match, ideal 0x0004.
    judge("match", 16'h0004, 16'h0004, 1'b0, 1'b1);
    @(negedge clk);
    chk("pulse_width", 32'(case_valid), 32'd0);

    // Single mismatch at slot 7 (cycle_index 9).
    judge("slot7", 16'h0004, 16'h0084, 1'b0, 1'b1);
    chk("slot7_xor", 32'(pred_vec ^ ideal_vec), 32'h0000_0080);

    // Mismatching garbage only at cycle_index 0 and 1.
    judge("garbage", 16'hA5C3, 16'hA5C3, 1'b1, 1'b1);

    // Partial wrong case abandoned by a counter restart, then a clean case.
    drive(0, 9, 16'h0000, 16'hFFFF, 1'b0);
    judge("restart", 16'h3C3C, 16'h3C3C, 1'b0, 1'b1);

    // Reset mid-capture at cycle_index 10.
    drive(0, 10, 16'h0004, 16'h0004, 1'b0);
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    drive(11, 17, 16'h0004, 16'h0004, 1'b0);
    @(negedge clk);
    cycle_index = 5'd0;
    chk("partial_valid", 32'(case_valid), 32'd0);
    chk("partial_total", total_cases, 32'd0);
    judge("after_reset", 16'h0004, 16'h0004, 1'b0, 1'b1);

    // Fresh start, then 150 correct cases.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 1; i <= 150; i++) begin
      judge("run", 16'(i * 37), 16'(i * 37), 1'b0, 1'b0);
    end
    chk("total_150", total_cases, 32'd150);
`ifdef EVAL_MOVING_WINDOW_EN
    chk("recent_full", 32'(recent_correct), 32'd100);
`else
    chk("recent_tied", 32'(recent_correct), 32'd0);
`endif

    // One wrong case evicts a correct entry; then a correct one evicts a correct one.
    judge("wrong_after_full", 16'h00FF, 16'h00FE, 1'b0, 1'b1);
    judge("right_after_wrong", 16'h1234, 16'h1234, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
